// File: rtl/voice_allocator_pkg.sv
// Shared types and widths for the voice allocator slice.
// Envelope and controller state encodings live here.
package keyboard_pkg;

    localparam int NOTE_W = 8;
    localparam int SHIFT_W = 4;
    localparam logic [NOTE_W-1:0] NOTE_SILENT = 8'h00;

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    typedef enum logic [1:0] {
        CTL_IDLE,
        CTL_MATCH,
        CTL_APPLY
    } ctl_state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_LOAD,
        ACT_RETRIG,
        ACT_RELEASE,
        ACT_HOLD
    } act_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Event handshake and per-voice output bundle.
// master = event source / mixer side, slave = allocator.
interface voice_allocator_if
    import keyboard_pkg::*;
#(
    parameter int NUM_VOICES = 3
);
    logic                          ev_valid;
    logic                          ev_ready;
    logic                          ev_down;
    logic [NOTE_W-1:0]             ev_note;
    logic [NOTE_W*NUM_VOICES-1:0]  voice_note;
    logic [SHIFT_W*NUM_VOICES-1:0] voice_shift;
    logic [NUM_VOICES-1:0]         voice_active;

    modport master (
        output ev_valid, ev_down, ev_note,
        input  ev_ready, voice_note, voice_shift, voice_active
    );

    modport slave (
        input  ev_valid, ev_down, ev_note,
        output ev_ready, voice_note, voice_shift, voice_active
    );
endinterface

// File: rtl/voice_allocator_envelope.sv
// One voice slot: note register plus attack/sustain/release envelope.
// Controller strobes take priority over the envelope step.
module voice_envelope
    import keyboard_pkg::*;
#(
    parameter int ATTACK_TICKS  = 2500000,
    parameter int RELEASE_TICKS = 9868928,
    parameter int MAX_SHIFT     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_retrig,
    input  logic               i_release,
    input  logic               i_hold,
    input  logic               i_pedal_up,
    input  logic [NOTE_W-1:0]  i_note,
    output logic [NOTE_W-1:0]  o_note,
    output logic [SHIFT_W-1:0] o_shift,
    output env_state_t         o_state
);
    localparam int CNT_W = $clog2(max2(ATTACK_TICKS, RELEASE_TICKS) + 1);
    localparam logic [CNT_W-1:0] ATK_LAST = CNT_W'(ATTACK_TICKS - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_TICKS - 1);
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(MAX_SHIFT);

    env_state_t         r_state;
    logic [SHIFT_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [NOTE_W-1:0]  r_note;
    logic               r_held;

    // Strobes first, then pedal release, then the envelope step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ENV_IDLE;
            r_shift <= SHIFT_MAX;
            r_cnt   <= '0;
            r_note  <= NOTE_SILENT;
            r_held  <= 1'b0;
        end else if (i_load) begin
            r_note  <= i_note;
            r_shift <= SHIFT_MAX;
            r_state <= ENV_ATTACK;
            r_cnt   <= '0;
            r_held  <= 1'b0;
        end else if (i_retrig) begin
            r_state <= ENV_ATTACK;
            r_cnt   <= '0;
            r_held  <= 1'b0;
        end else if (i_release) begin
            r_state <= ENV_RELEASE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
        end else if (i_hold) begin
            r_held  <= 1'b1;
        end else if (i_pedal_up && r_held) begin
            r_state <= ENV_RELEASE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
        end else begin
            unique case (r_state)
                ENV_IDLE: begin
                    r_cnt <= '0;
                end
                ENV_ATTACK: begin
                    if (r_cnt == ATK_LAST) begin
                        r_cnt <= '0;
                        if (r_shift <= SHIFT_W'(1)) begin
                            r_shift <= '0;
                            r_state <= ENV_SUSTAIN;
                        end else begin
                            r_shift <= r_shift - SHIFT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ENV_SUSTAIN: begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                end
                ENV_RELEASE: begin
                    if (r_cnt == REL_LAST) begin
                        r_cnt <= '0;
                        if (r_shift >= SHIFT_MAX - SHIFT_W'(1)) begin
                            r_shift <= SHIFT_MAX;
                            r_state <= ENV_IDLE;
                            r_note  <= NOTE_SILENT;
                        end else begin
                            r_shift <= r_shift + SHIFT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign o_note  = r_note;
    assign o_shift = r_shift;
    assign o_state = r_state;
endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: match/allocate/steal controller with LRU ranks.
// Optional macro SUSTAIN_PEDAL_EN adds the sustain_pedal input.
module voice_allocator
    import keyboard_pkg::*;
#(
    parameter int NUM_VOICES    = 3,
    parameter int ATTACK_TICKS  = 2500000,
    parameter int RELEASE_TICKS = 9868928,
    parameter int MAX_SHIFT     = 8
) (
    input logic clk,
    input logic reset,
`ifdef SUSTAIN_PEDAL_EN
    input logic sustain_pedal,
`endif
    voice_allocator_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    typedef logic [IDX_W-1:0] idx_t;

    ctl_state_t        r_ctl;
    logic              r_ready;
    logic              r_down;
    logic [NOTE_W-1:0] r_note;
    act_t              r_act;
    idx_t              r_tgt;
    idx_t              r_rank [NUM_VOICES];

    logic [NOTE_W-1:0]  w_note  [NUM_VOICES];
    logic [SHIFT_W-1:0] w_shift [NUM_VOICES];
    env_state_t         w_state [NUM_VOICES];
    logic w_hit;
    logic w_free;
    idx_t w_hit_idx;
    idx_t w_free_idx;
    idx_t w_old_idx;
    act_t w_act;
    idx_t w_tgt;
    logic w_pedal;
    logic w_pedal_up;

`ifdef SUSTAIN_PEDAL_EN
    logic r_pedal;

    // Previous pedal level, for the falling-edge release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pedal <= 1'b0;
        else       r_pedal <= sustain_pedal;
    end

    assign w_pedal    = sustain_pedal;
    assign w_pedal_up = r_pedal & ~sustain_pedal;
`else
    assign w_pedal    = 1'b0;
    assign w_pedal_up = 1'b0;
`endif

    // Find same-note voice, lowest idle voice and oldest voice.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_old_idx  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_state[i] != ENV_IDLE && w_note[i] == r_note) begin
                w_hit     = 1'b1;
                w_hit_idx = idx_t'(i);
            end
            if (w_state[i] == ENV_IDLE && !w_free) begin
                w_free     = 1'b1;
                w_free_idx = idx_t'(i);
            end
            if (r_rank[i] == idx_t'(NUM_VOICES - 1)) w_old_idx = idx_t'(i);
        end
    end

    // Pick the action and target voice for the latched event.
    always_comb begin
        w_act = ACT_NONE;
        w_tgt = w_hit_idx;
        if (r_note == NOTE_SILENT) begin
            w_act = ACT_NONE;
        end else if (r_down) begin
            if (w_hit) begin
                w_act = ACT_RETRIG;
            end else if (w_free) begin
                w_act = ACT_LOAD;
                w_tgt = w_free_idx;
            end else begin
                w_act = ACT_LOAD;
                w_tgt = w_old_idx;
            end
        end else if (w_hit && (w_state[w_hit_idx] == ENV_ATTACK ||
                               w_state[w_hit_idx] == ENV_SUSTAIN)) begin
            w_act = w_pedal ? ACT_HOLD : ACT_RELEASE;
        end
    end

    // Controller FSM: latch event, decide, apply and age LRU ranks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctl   <= CTL_IDLE;
            r_ready <= 1'b1;
            r_down  <= 1'b0;
            r_note  <= NOTE_SILENT;
            r_act   <= ACT_NONE;
            r_tgt   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) r_rank[i] <= idx_t'(i);
        end else begin
            case (r_ctl)
                CTL_IDLE: begin
                    if (bus.ev_valid && r_ready) begin
                        r_note  <= bus.ev_note;
                        r_down  <= bus.ev_down;
                        r_ready <= 1'b0;
                        r_ctl   <= CTL_MATCH;
                    end
                end
                CTL_MATCH: begin
                    r_act <= w_act;
                    r_tgt <= w_tgt;
                    r_ctl <= CTL_APPLY;
                end
                CTL_APPLY: begin
                    r_ready <= 1'b1;
                    r_ctl   <= CTL_IDLE;
                    if (r_act == ACT_LOAD || r_act == ACT_RETRIG) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (idx_t'(i) == r_tgt)
                                r_rank[i] <= '0;
                            else if (r_rank[i] < r_rank[r_tgt])
                                r_rank[i] <= r_rank[i] + idx_t'(1);
                        end
                    end
                end
                default: begin
                    r_ctl   <= CTL_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        logic w_sel;
        assign w_sel = (r_ctl == CTL_APPLY) && (r_tgt == idx_t'(g));

        voice_envelope #(
            .ATTACK_TICKS (ATTACK_TICKS),
            .RELEASE_TICKS(RELEASE_TICKS),
            .MAX_SHIFT    (MAX_SHIFT)
        ) u_env (
            .clk       (clk),
            .reset     (reset),
            .i_load    (w_sel && r_act == ACT_LOAD),
            .i_retrig  (w_sel && r_act == ACT_RETRIG),
            .i_release (w_sel && r_act == ACT_RELEASE),
            .i_hold    (w_sel && r_act == ACT_HOLD),
            .i_pedal_up(w_pedal_up),
            .i_note    (r_note),
            .o_note    (w_note[g]),
            .o_shift   (w_shift[g]),
            .o_state   (w_state[g])
        );
    end

    // Pack per-voice registers onto the output bus.
    always_comb begin
        bus.voice_note   = '0;
        bus.voice_shift  = '0;
        bus.voice_active = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            bus.voice_note[i*NOTE_W +: NOTE_W]    = w_note[i];
            bus.voice_shift[i*SHIFT_W +: SHIFT_W] = w_shift[i];
            bus.voice_active[i] = (w_state[i] != ENV_IDLE);
        end
    end

    assign bus.ev_ready = r_ready;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: time-based voice model plus directed vectors.
// Build with SUSTAIN_PEDAL_EN defined to exercise the pedal path.
module tb_voice_allocator;
    localparam int NV = 3;
    localparam int AT = 4;
    localparam int RT = 6;
    localparam int MS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SUSTAIN_PEDAL_EN
    logic pedal = 1'b0;
    bit   m_ped_prev;
`endif

    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_VOICES(NV)) bus();

    voice_allocator #(
        .NUM_VOICES   (NV),
        .ATTACK_TICKS (AT),
        .RELEASE_TICKS(RT),
        .MAX_SHIFT    (MS)
    ) dut (
        .clk          (clk),
        .reset        (rst),
`ifdef SUSTAIN_PEDAL_EN
        .sustain_pedal(pedal),
`endif
        .bus          (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: mode 0 idle, 1 attack/sustain, 2 release; shift follows time.
    int       m_mode [NV];
    int       m_base [NV];
    int       m_t0   [NV];
    int       m_rank [NV];
    bit       m_held [NV];
    logic [7:0] m_note [NV];
    bit       m_pend;
    int       m_apply;
    logic [7:0] m_evn;
    bit       m_evd;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int v = 0; v < NV; v++) begin
            m_mode[v] = 0;
            m_base[v] = MS;
            m_t0[v]   = 0;
            m_rank[v] = v;
            m_held[v] = 1'b0;
            m_note[v] = 8'h00;
        end
        m_pend = 1'b0;
        cyc    = 0;
`ifdef SUSTAIN_PEDAL_EN
        m_ped_prev = 1'b0;
`endif
    endfunction

    function automatic int m_sh(input int v, input int c);
        int s;
        if (m_mode[v] == 1) begin
            s = m_base[v] - (c - m_t0[v]) / AT;
            return (s < 0) ? 0 : s;
        end
        if (m_mode[v] == 2) begin
            s = m_base[v] + (c - m_t0[v]) / RT;
            return (s > MS) ? MS : s;
        end
        return MS;
    endfunction

    function automatic bit m_act(input int v, input int c);
        int k;
        if (m_mode[v] == 1) return 1'b1;
        if (m_mode[v] == 2) begin
            k = (c - m_t0[v]) / RT;
            return !(k > 0 && m_base[v] + k >= MS);
        end
        return 1'b0;
    endfunction

    function automatic void m_release(input int v, input int c);
        m_base[v] = m_sh(v, c - 1);
        m_mode[v] = 2;
        m_t0[v]   = c;
        m_held[v] = 1'b0;
    endfunction

    function automatic void m_do(input int c);
        int hit = -1;
        int fr  = -1;
        int old = 0;
        int tgt;
        int r;
        if (m_evn == 8'h00) return;
        for (int v = 0; v < NV; v++)
            if (m_act(v, c - 1) && m_note[v] == m_evn) hit = v;
        if (m_evd) begin
            if (hit >= 0) begin
                tgt = hit;
                m_base[tgt] = m_sh(tgt, c - 1);
            end else begin
                for (int v = NV - 1; v >= 0; v--)
                    if (!m_act(v, c - 1)) fr = v;
                for (int v = 0; v < NV; v++)
                    if (m_rank[v] == NV - 1) old = v;
                tgt = (fr >= 0) ? fr : old;
                m_base[tgt] = MS;
                m_note[tgt] = m_evn;
            end
            m_mode[tgt] = 1;
            m_t0[tgt]   = c;
            m_held[tgt] = 1'b0;
            r = m_rank[tgt];
            for (int v = 0; v < NV; v++)
                if (m_rank[v] < r) m_rank[v]++;
            m_rank[tgt] = 0;
        end else if (hit >= 0 && m_mode[hit] == 1) begin
`ifdef SUSTAIN_PEDAL_EN
            if (pedal) m_held[hit] = 1'b1;
            else       m_release(hit, c);
`else
            m_release(hit, c);
`endif
        end
    endfunction

    // Advance the model one clock and apply any due event.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reset();
        end else begin
            cyc++;
`ifdef SUSTAIN_PEDAL_EN
            if (m_ped_prev && !pedal)
                for (int v = 0; v < NV; v++)
                    if (m_held[v]) m_release(v, cyc);
            m_ped_prev = pedal;
`endif
            if (m_pend && cyc == m_apply) begin
                m_do(cyc);
                m_pend = 1'b0;
            end else if (!m_pend && bus.ev_valid) begin
                m_pend  = 1'b1;
                m_apply = cyc + 2;
                m_evn   = bus.ev_note;
                m_evd   = bus.ev_down;
            end
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        logic [8*NV-1:0] en;
        logic [4*NV-1:0] es;
        logic [NV-1:0]   ea;
        if (!rst) begin
            for (int v = 0; v < NV; v++) begin
                ea[v] = m_act(v, cyc);
                en[v*8 +: 8] = ea[v] ? m_note[v] : 8'h00;
                es[v*4 +: 4] = 4'(m_sh(v, cyc));
            end
            chk("model_ready", 32'(bus.ev_ready), 32'(!m_pend));
            chk("model_note", 32'(bus.voice_note), 32'(en));
            chk("model_shift", 32'(bus.voice_shift), 32'(es));
            chk("model_active", 32'(bus.voice_active), 32'(ea));
        end
    end

    task automatic send(input bit d, input logic [7:0] n);
        int w = 0;
        while (!bus.ev_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.ev_valid = 1'b1;
        bus.ev_down  = d;
        bus.ev_note  = n;
        @(posedge clk);
        @(negedge clk);
        bus.ev_valid = 1'b0;
        chk("busy1", 32'(bus.ev_ready), 32'd0);
        @(negedge clk);
        chk("busy2", 32'(bus.ev_ready), 32'd0);
        @(negedge clk);
        chk("ready_back", 32'(bus.ev_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        bus.ev_valid = 1'b0;
        bus.ev_down  = 1'b0;
        bus.ev_note  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_note", 32'(bus.voice_note), 32'h0);
        chk("rst_shift", 32'(bus.voice_shift), 32'h888);
        chk("rst_active", 32'(bus.voice_active), 32'h0);
        chk("rst_ready", 32'(bus.ev_ready), 32'h1);

        send(1'b1, 8'h3C);
        chk("p3c_note", 32'(bus.voice_note[7:0]), 32'h3C);
        chk("p3c_shift", 32'(bus.voice_shift[3:0]), 32'd8);
        chk("p3c_active", 32'(bus.voice_active), 32'b001);
        repeat (31) @(negedge clk);
        chk("atk31_shift", 32'(bus.voice_shift[3:0]), 32'd1);
        @(negedge clk);
        chk("atk32_shift", 32'(bus.voice_shift[3:0]), 32'd0);

        send(1'b0, 8'h3C);
        repeat (47) @(negedge clk);
        chk("rel47_shift", 32'(bus.voice_shift[3:0]), 32'd7);
        chk("rel47_active", 32'(bus.voice_active), 32'b001);
        @(negedge clk);
        chk("rel48_note", 32'(bus.voice_note), 32'h0);
        chk("rel48_active", 32'(bus.voice_active), 32'b000);
        chk("rel48_shift", 32'(bus.voice_shift[3:0]), 32'd8);

        send(1'b1, 8'h3C);
        send(1'b1, 8'h40);
        send(1'b1, 8'h43);
        send(1'b1, 8'h48);
        chk("steal_notes", 32'(bus.voice_note), 32'h434048);
        chk("steal_shift", 32'(bus.voice_shift[3:0]), 32'd8);
        chk("steal_active", 32'(bus.voice_active), 32'b111);
        send(1'b1, 8'h4C);
        chk("steal2_notes", 32'(bus.voice_note), 32'h434C48);

        do_reset();
        send(1'b1, 8'h3C);
        repeat (9) @(negedge clk);
        send(1'b1, 8'h3C);
        chk("retrig_shift", 32'(bus.voice_shift[3:0]), 32'd6);
        chk("retrig_active", 32'(bus.voice_active), 32'b001);
        repeat (4) @(negedge clk);
        chk("retrig_step", 32'(bus.voice_shift[3:0]), 32'd5);
        repeat (30) @(negedge clk);
        send(1'b0, 8'h55);
        send(1'b1, 8'h00);
        chk("ign_note", 32'(bus.voice_note), 32'h00003C);
        chk("ign_shift", 32'(bus.voice_shift[3:0]), 32'd0);
        chk("ign_active", 32'(bus.voice_active), 32'b001);

        bus.ev_valid = 1'b1;
        bus.ev_down  = 1'b1;
        bus.ev_note  = 8'h40;
        @(posedge clk);
        @(negedge clk);
        bus.ev_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_note", 32'(bus.voice_note), 32'h0);
        chk("mid_rst_shift", 32'(bus.voice_shift), 32'h888);
        chk("mid_rst_active", 32'(bus.voice_active), 32'h0);
        chk("mid_rst_ready", 32'(bus.ev_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("dropped_ev", 32'(bus.voice_active), 32'h0);

`ifdef SUSTAIN_PEDAL_EN
        do_reset();
        pedal = 1'b1;
        send(1'b1, 8'h3C);
        send(1'b0, 8'h3C);
        repeat (40) @(negedge clk);
        chk("pedal_hold_active", 32'(bus.voice_active), 32'b001);
        chk("pedal_hold_shift", 32'(bus.voice_shift[3:0]), 32'd0);
        pedal = 1'b0;
        @(negedge clk);
        repeat (6) @(negedge clk);
        chk("pedal_rel_shift", 32'(bus.voice_shift[3:0]), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules the shared three-voice note datapath (note1..note3 → add_notes → amplitude shift) between a stream of key-down/key-up events decoded from SPI frames.
- Allocates each pressed note to a voice slot, steals the least-recently-allocated slot when all are busy, and runs a per-voice attack/sustain/release envelope.
- Outputs per-voice note code and right-shift attenuation amount for the downstream mixer.

Parameters:
- NUM_VOICES, 3, number of voice slots (2..8).
- ATTACK_TICKS, 2500000, clk cycles per attack step (shift −1).
- RELEASE_TICKS, 9868928, clk cycles per release step (shift +1).
- MAX_SHIFT, 8, attenuation shift meaning silence; also the attack start value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  block can accept an event this cycle.
- ev_down  in  1  1 = key press, 0 = key release.
- ev_note  in  8  note code; 8'h00 is reserved as silence and ignored.
- voice_note  out  8*NUM_VOICES  note code per voice, voice i at [8i+7:8i].
- voice_shift  out  4*NUM_VOICES  attenuation shift per voice.
- voice_active  out  NUM_VOICES  voice not IDLE.

Behaviour:
- Reset (async): all voices IDLE, voice_note=0, voice_shift=MAX_SHIFT, voice_active=0, LRU rank[i]=i, ev_ready=1, step counters=0.
- Handshake: event accepted when ev_valid && ev_ready. Controller FSM CTL_IDLE → CTL_MATCH → CTL_APPLY → CTL_IDLE. ev_ready=1 only in CTL_IDLE. Event is latched on accept. Voice outputs change on the CTL_APPLY edge, 2 cycles after accept. Max throughput is 1 event per 3 cycles.
- Key-down, in priority order:
  - Same note is already on a non-IDLE voice: retrigger it. State becomes ATTACK, shift keeps its current value, step counter clears.
  - Otherwise, take the lowest-index IDLE voice.
  - Otherwise, steal the voice with the highest LRU rank (oldest). It loads the note, shift=MAX_SHIFT, state ATTACK.
- LRU update: the chosen voice's rank becomes 0. Ranks lower than its old rank increment. Ranks always remain a permutation of 0..NUM_VOICES−1.
- Key-up: matching voice in ATTACK or SUSTAIN enters RELEASE with its counter cleared. If no match, or the voice is already in RELEASE/IDLE, nothing changes.
- ev_note=0: accepted and discarded; no state change.
- Envelope per voice, states IDLE/ATTACK/SUSTAIN/RELEASE:
  - ATTACK: counter counts to ATTACK_TICKS−1, then shift decrements and counter clears. The step that makes shift 0 also moves the voice to SUSTAIN.
  - SUSTAIN: shift=0, holds indefinitely.
  - RELEASE: same scheme with RELEASE_TICKS, shift incrementing. The step reaching MAX_SHIFT moves to IDLE, voice_note←0, active←0.
  - Shift saturates in [0, MAX_SHIFT] and never wraps.
- Simultaneous events: when CTL_APPLY targets a voice in the same cycle its envelope would step, the APPLY result wins and the step is discarded. Envelopes of other voices step normally.
- Reset asserted mid-event drops the latched event with no partial update.

Optional Feature:
- SUSTAIN_PEDAL_EN adds input sustain_pedal (1 bit).
- Defined: a key-up while the pedal is high sets a per-voice held flag and does not enter RELEASE. When the pedal falls, every held voice enters RELEASE on the next cycle and its flag clears. A key-down retrigger clears held.
- Undefined: port absent, key-up always releases immediately.

Decomposition:
- Package keyboard_pkg:
  - env_state_t enum {ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE}.
  - ctl_state_t enum.
  - NOTE_W=8, SHIFT_W=4, NOTE_SILENT=8'h00.
- Sub-module voice_envelope, instantiated once per voice by generate.
  - Owns one voice's state, shift, counter and note register.
  - Takes load/retrigger/release strobes from the controller.
  - Controller keeps the match/allocate logic and LRU ranks.

Test Plan:
Sim parameters: ATTACK_TICKS=4, RELEASE_TICKS=6, MAX_SHIFT=8, NUM_VOICES=3.
- Reset, then press 8'h3C → 2 cycles after accept, voice0 note=3C, shift=8, active=1. Shift reaches 0 after 32 cycles and the voice is in SUSTAIN. ev_ready is low for exactly 2 cycles after accept.
- Press 3C, wait for SUSTAIN, release 3C → shift rises by 1 every 6 cycles. After 48 cycles voice0 is IDLE, note=0, active=0.
- Press 3C, 40, 43, then 48 → 48 steals voice0 (oldest) with shift=8. Voices 1 and 2 are unchanged. Ranks become v0=0, v2=1, v1=2.
- Press 3C and wait 10 cycles (shift=6), then press 3C again → same voice retriggers, shift stays 6, no other voice is allocated.
- Release 55 (not playing) and press 00 → both accepted, no output change. Assert reset during CTL_MATCH → all outputs return to reset values immediately.
- With SUSTAIN_PEDAL_EN: pedal=1, press and release 3C → voice stays SUSTAIN. Pedal falls → RELEASE begins the next cycle.
